toggle_event_rx: RTL and testbench

TOGGLE_EVENT_RX -- requirements
Module: toggle_event_rx

---
 rtl/toggle_event_rx.sv | 136 +++++++++++++
 tb/tb_toggle_event_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_rx.sv
// Toggle-encoded event receiver: counts level changes on t_in into a saturating pending counter.
// Optional 2-flop input synchronizer enabled by defining TOGGLE_EVENT_RX_SYNC_EN.
module toggle_event_rx #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic             evt_pulse,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovf
);

    typedef enum logic [1:0] {
        RST,
        ARM,
        RUN
    } state_t;

    logic last;

`ifdef TOGGLE_EVENT_RX_SYNC_EN
    localparam int NS = 2;
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], t_in};
        end
    end

    assign last = sync[1];
`else
    localparam int NS = 1;
    logic samp;

    always_ff @(posedge clk) begin
        if (reset) begin
            samp <= 1'b0;
        end else begin
            samp <= t_in;
        end
    end

    assign last = samp;
`endif

    state_t           state;
    state_t           state_next;
    logic             arm_cnt;
    logic             arm_next;
    logic             prev;
    logic             running;
    logic             det;
    logic             pop;
    logic             full;
    logic             sat_loss;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RST;
            arm_cnt <= 1'b0;
        end else begin
            state   <= state_next;
            arm_cnt <= arm_next;
        end
    end

    // ARM waits until the sampling pipeline holds the post-reset level; prev tracks it throughout.
    always_comb begin
        state_next = state;
        arm_next   = arm_cnt;
        case (state)
            RST: begin
                state_next = ARM;
                arm_next   = 1'b0;
            end
            ARM: begin
                if (arm_cnt == 1'(NS - 1)) begin
                    state_next = RUN;
                end else begin
                    arm_next = arm_cnt + 1'b1;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = RST;
        endcase
    end

    assign running   = (state == RUN);
    assign det       = running & (last ^ prev);
    assign evt_valid = (pend_cnt != '0);
    assign pop       = running & evt_valid & evt_ready;
    assign full      = (pend_cnt == '1);
    assign sat_loss  = det & ~pop & full;

    always_comb begin
        cnt_next = pend_cnt;
        case ({det, pop})
            2'b10: if (!full) cnt_next = pend_cnt + CNT_W'(1);
            2'b01: cnt_next = pend_cnt - CNT_W'(1);
            default: cnt_next = pend_cnt;
        endcase
    end

    always_comb begin
        ovf_next = ovf;
        if (sat_loss) begin
            ovf_next = 1'b1;
        end else if (clr_ovf) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev      <= 1'b0;
            pend_cnt  <= '0;
            evt_pulse <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            prev      <= last;
            pend_cnt  <= cnt_next;
            evt_pulse <= det;
            ovf       <= ovf_next;
        end
    end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Scoreboard bench for toggle_event_rx: toggles push expected (pend_cnt, ovf) at strobe time,
// a negedge monitor pops and compares on every evt_pulse.
module tb_toggle_event_rx;

    localparam int CNT_W = 4;
`ifdef TOGGLE_EVENT_RX_SYNC_EN
    localparam int NS = 2;
`else
    localparam int NS = 1;
`endif

    logic             clk;
    logic             reset;
    logic             t_in;
    logic             evt_ready;
    logic             clr_ovf;
    logic             evt_valid;
    logic             evt_pulse;
    logic [CNT_W-1:0] pend_cnt;
    logic             ovf;

    typedef struct {
        int cnt;
        int ov;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;
    int   pulses;

    toggle_event_rx #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .t_in      (t_in),
        .evt_ready (evt_ready),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .evt_pulse (evt_pulse),
        .pend_cnt  (pend_cnt),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_push(input int cnt, input int ov);
        exp_t e;
        e.cnt = cnt;
        e.ov  = ov;
        exp_q.push_back(e);
        t_in = ~t_in;
    endtask

    task automatic drain_check(input string name);
        repeat (NS + 3) tick();
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (evt_pulse === 1'b1) begin
            exp_t e;
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cnt", int'(pend_cnt), e.cnt);
                check("pulse_ovf", int'(ovf), e.ov);
            end
        end
    end

    initial begin
        int pop_seq[6];
        tests     = 0;
        fails     = 0;
        pulses    = 0;
        reset     = 1'b1;
        t_in      = 1'b1;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_cnt", int'(pend_cnt), 0);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_pulse", int'(evt_pulse), 0);
        check("rst_ovf", int'(ovf), 0);

        // Arm: level held across release must not count
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("arm_quiet", int'({evt_pulse, evt_valid, pend_cnt}), 0);
        end

        // Latency: strobe only in the cycle after edge N+NS
        tick();
        toggle_push(1, 0);
        for (int j = 0; j <= NS + 2; j++) begin
            @(negedge clk);
            check("latency_pulse", int'(evt_pulse), (j == NS + 1) ? 1 : 0);
        end
        check("latency_cnt", int'(pend_cnt), 1);
        check("latency_valid", int'(evt_valid), 1);

        // Build up to 3 then pop while one event arrives
        tick();
        toggle_push(2, 0);
        repeat (2) tick();
        toggle_push(3, 0);
        repeat (NS + 2) tick();
        @(negedge clk);
        check("pre_pop_cnt", int'(pend_cnt), 3);
        tick();
        evt_ready = 1'b1;
`ifdef TOGGLE_EVENT_RX_SYNC_EN
        toggle_push(1, 0);
        pop_seq = '{3, 2, 1, 1, 0, 0};
`else
        toggle_push(2, 0);
        pop_seq = '{3, 2, 2, 1, 0, 0};
`endif
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("pop_seq", int'(pend_cnt), pop_seq[j]);
        end
        check("pop_valid", int'(evt_valid), 0);
        tick();
        evt_ready = 1'b0;
        drain_check("pop_drain");

        // Saturation: 17 toggles with no pops
        pulses = 0;
        for (int i = 1; i <= 17; i++) begin
            toggle_push((i > 15) ? 15 : i, (i > 15) ? 1 : 0);
            repeat (2) tick();
        end
        drain_check("sat_drain");
        check("sat_pulses", pulses, 17);
        @(negedge clk);
        check("sat_cnt", int'(pend_cnt), 15);
        check("sat_ovf", int'(ovf), 1);

        // clr_ovf coincident with a saturation loss: loss wins
        tick();
        toggle_push(15, 1);
        repeat (NS) tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        check("clr_vs_loss_ovf", int'(ovf), 1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        check("clr_alone_ovf", int'(ovf), 0);
        check("clr_alone_cnt", int'(pend_cnt), 15);

        // Mid-operation reset with 5 pending
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        for (int i = 1; i <= 5; i++) begin
            toggle_push(i, 0);
            repeat (2) tick();
        end
        drain_check("mid_build_drain");
        @(negedge clk);
        check("mid_pre_cnt", int'(pend_cnt), 5);
        tick();
        t_in  = ~t_in;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_cnt", int'(pend_cnt), 0);
        check("mid_rst_ovf", int'(ovf), 0);
        check("mid_rst_valid", int'(evt_valid), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rearm_quiet", int'({evt_pulse, pend_cnt}), 0);
        end
        tick();
        toggle_push(1, 0);
        drain_check("rearm_drain");
        @(negedge clk);
        check("rearm_cnt", int'(pend_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
